// File: rtl/disp_fade.sv
`timescale 1ns/1ps
// disp_fade: screen-swap fader placed after the text/game display mux.
// Delays the mux timing/RGB stream by two cycles while scaling RGB by a
// 0..16 brightness level. A game_state change fades the picture to black,
// swaps the mux select (state_disp) on a frame boundary while black, then
// fades back up.
module disp_fade #(
    parameter int unsigned FRAMES_PER_STEP = 2,
    parameter int unsigned STEP            = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [2:0]  game_state,
    output logic [2:0]  state_disp,
    output logic        fade_busy,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    localparam logic [4:0] LVL_MAX  = 5'd16;
    localparam logic [4:0] LVL_STEP = 5'(STEP);
    localparam logic [3:0] CNT_LAST = 4'(FRAMES_PER_STEP - 1);

    // Control state
    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_level;
    logic [4:0]  w_level_nxt;
    logic [3:0]  r_frame_cnt;
    logic [3:0]  w_frame_cnt_nxt;
    logic [2:0]  r_state_disp;
    logic [2:0]  w_state_disp_nxt;
    logic        r_vblnk_prev;
    logic        r_fade_busy;

    logic        w_frame_tick;
    logic        w_step_tick;
    logic [4:0]  w_level_dec;
    logic [5:0]  w_level_sum;
    logic [4:0]  w_level_inc;

    // Pipeline stage 1
    logic [10:0] r_s1_hcount;
    logic        r_s1_hsync;
    logic        r_s1_hblnk;
    logic [10:0] r_s1_vcount;
    logic        r_s1_vsync;
    logic        r_s1_vblnk;
    logic [11:0] r_s1_rgb;
    logic [4:0]  r_s1_level;

    // Pipeline stage 2 (drives the output pins)
    logic [10:0] r_s2_hcount;
    logic        r_s2_hsync;
    logic        r_s2_hblnk;
    logic [10:0] r_s2_vcount;
    logic        r_s2_vsync;
    logic        r_s2_vblnk;
    logic [11:0] r_s2_rgb;
    logic [11:0] w_rgb_scaled;

    // Scale one 4-bit channel by level/16; level 16 passes the channel unchanged
    function automatic logic [3:0] scale_ch(input logic [3:0] ch, input logic [4:0] lvl);
        logic [8:0] prod;
        prod = {5'b0, ch} * {4'b0, lvl};
        return prod[7:4];
    endfunction

    assign w_frame_tick = vblnk_in & ~r_vblnk_prev;
    assign w_step_tick  = w_frame_tick && (r_frame_cnt == CNT_LAST);
    assign w_level_dec  = (r_level < LVL_STEP) ? '0 : (r_level - LVL_STEP);
    assign w_level_sum  = {1'b0, r_level} + {1'b0, LVL_STEP};
    assign w_level_inc  = (w_level_sum > {1'b0, LVL_MAX}) ? LVL_MAX : w_level_sum[4:0];

    // FSM next-state, brightness level and displayed-state update
    always_comb begin
        w_state_nxt      = r_state;
        w_level_nxt      = r_level;
        w_state_disp_nxt = r_state_disp;
        case (r_state)
            IDLE: begin
                w_level_nxt = LVL_MAX;
                if (game_state != r_state_disp) begin
                    w_state_nxt = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (w_step_tick) begin
                    w_level_nxt = w_level_dec;
                    if (w_level_dec == '0) begin
                        w_state_nxt = SWAP;
                    end
                end
            end
            SWAP: begin
                w_level_nxt = '0;
                if (w_frame_tick) begin
                    w_state_disp_nxt = game_state;
                    w_state_nxt      = FADE_IN;
                end
            end
            FADE_IN: begin
                if (w_step_tick) begin
                    w_level_nxt = w_level_inc;
                    if (w_level_inc == LVL_MAX) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_level_nxt = LVL_MAX;
            end
        endcase
    end

    // Frame counter: cleared on every state entry, wraps on each step tick
    always_comb begin
        w_frame_cnt_nxt = r_frame_cnt;
        if (w_state_nxt != r_state) begin
            w_frame_cnt_nxt = '0;
        end else if (w_step_tick) begin
            w_frame_cnt_nxt = '0;
        end else if (w_frame_tick) begin
            w_frame_cnt_nxt = r_frame_cnt + 4'd1;
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_level      <= LVL_MAX;
            r_frame_cnt  <= '0;
            r_state_disp <= '0;
            r_vblnk_prev <= 1'b0;
            r_fade_busy  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_state_disp <= w_state_disp_nxt;
            r_vblnk_prev <= vblnk_in;
            r_fade_busy  <= (w_state_nxt != IDLE);
        end
    end

    // Stage 1: capture the mux stream together with the current level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_hcount <= '0;
            r_s1_hsync  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_vcount <= '0;
            r_s1_vsync  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_rgb    <= '0;
            r_s1_level  <= '0;
        end else begin
            r_s1_hcount <= hcount_in;
            r_s1_hsync  <= hsync_in;
            r_s1_hblnk  <= hblnk_in;
            r_s1_vcount <= vcount_in;
            r_s1_vsync  <= vsync_in;
            r_s1_vblnk  <= vblnk_in;
            r_s1_rgb    <= rgb_in;
            r_s1_level  <= r_level;
        end
    end

    assign w_rgb_scaled = (r_s1_hblnk | r_s1_vblnk) ? '0 :
                          {scale_ch(r_s1_rgb[11:8], r_s1_level),
                           scale_ch(r_s1_rgb[7:4],  r_s1_level),
                           scale_ch(r_s1_rgb[3:0],  r_s1_level)};

    // Stage 2: scaled colour and delayed timing to the output pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_hcount <= '0;
            r_s2_hsync  <= 1'b0;
            r_s2_hblnk  <= 1'b0;
            r_s2_vcount <= '0;
            r_s2_vsync  <= 1'b0;
            r_s2_vblnk  <= 1'b0;
            r_s2_rgb    <= '0;
        end else begin
            r_s2_hcount <= r_s1_hcount;
            r_s2_hsync  <= r_s1_hsync;
            r_s2_hblnk  <= r_s1_hblnk;
            r_s2_vcount <= r_s1_vcount;
            r_s2_vsync  <= r_s1_vsync;
            r_s2_vblnk  <= r_s1_vblnk;
            r_s2_rgb    <= w_rgb_scaled;
        end
    end

    assign state_disp = r_state_disp;
    assign fade_busy  = r_fade_busy;
    assign hcount_out = r_s2_hcount;
    assign hsync_out  = r_s2_hsync;
    assign hblnk_out  = r_s2_hblnk;
    assign vcount_out = r_s2_vcount;
    assign vsync_out  = r_s2_vsync;
    assign vblnk_out  = r_s2_vblnk;
    assign rgb_out    = r_s2_rgb;

endmodule
